// File: rtl/iic_slave_pkg.sv
// Shared types and constants for the I2C slave register-file model.
package iic_slave_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WR_DATA   = 4'd5,
    S_WR_ACK    = 4'd6,
    S_RD_DATA   = 4'd7,
    S_RD_MACK   = 4'd8,
    S_WAIT_STOP = 4'd9
  } iic_slave_state_t;

  localparam logic       IIC_ACK  = 1'b0;
  localparam logic       IIC_NACK = 1'b1;
  localparam logic [3:0] IIC_BITS = 4'd8;

endpackage

// File: rtl/iic_bus_sync_detect.sv
// SCL/SDA synchroniser with registered START/STOP and SCL edge detection.
module iic_bus_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [SYNC_STAGES-1:0] scl_pipe_q, scl_pipe_d, sda_pipe_q, sda_pipe_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic start_q, start_d, stop_q, stop_d, sda_sync_q, sda_sync_d;
  logic scl_now, sda_now;

  assign scl_now = scl_pipe_q[SYNC_STAGES-1];
  assign sda_now = sda_pipe_q[SYNC_STAGES-1];

  // SCL edges that coincide with a START/STOP detection are suppressed
  always_comb begin
    scl_pipe_d = {scl_pipe_q[SYNC_STAGES-2:0], scl_i};
    sda_pipe_d = {sda_pipe_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_now;
    sda_prev_d = sda_now;
    sda_sync_d = sda_now;
    start_d    = scl_prev_q & scl_now & sda_prev_q & ~sda_now;
    stop_d     = scl_prev_q & scl_now & ~sda_prev_q & sda_now;
    scl_rise_d = ~scl_prev_q & scl_now & ~start_d & ~stop_d;
    scl_fall_d = scl_prev_q & ~scl_now & ~start_d & ~stop_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_pipe_q <= {SYNC_STAGES{1'b1}};
      sda_pipe_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      sda_sync_q <= sda_sync_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_sync  = sda_sync_q;

endmodule

// File: rtl/iic_slave_regfile.sv
// I2C slave with pointer-addressed register file, ACK/read-data drive on SDA.
// Optional sticky interrupt enabled by defining IIC_SLAVE_IRQ_EN.
module iic_slave_regfile
  import iic_slave_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h53,
  parameter int         REG_DEPTH   = 64,
  parameter logic [7:0] DEVID_VALUE = 8'hE5,
  parameter logic [7:0] IRQ_CLR_REG = 8'h30,
  parameter int         SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic IIC_SCL_I,
  input  logic IIC_SDA_I,
  output logic IIC_SCL_O,
  output logic IIC_SDA_O,
  output logic IRQ
);

  localparam int PW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  iic_slave_state_t state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc, rd_addr;
  logic          rw_q, rw_d, sda_o_q, sda_o_d;
  logic          wr_en, rd_load, byte_done;
  logic [7:0]    rx_byte;
  logic [7:0]    mem_q [REG_DEPTH];
  logic          scl_rise, scl_fall, start_det, stop_det, sda_sync;

  iic_bus_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(reset), .scl_i(IIC_SCL_I), .sda_i(IIC_SDA_I),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .stop_det(stop_det), .sda_sync(sda_sync)
  );

  function automatic logic [7:0] reg_read(input logic [PW-1:0] a);
    return (a == PTR_ZERO) ? DEVID_VALUE : mem_q[a];
  endfunction

  assign rx_byte   = {rx_q, sda_sync};
  assign ptr_inc   = ptr_q + PTR_ONE;
  assign byte_done = (bit_cnt_q == (IIC_BITS - 4'd1));

  // Ack states: the first SCL fall drives ACK, the fall after the 9th rise leaves
  always_comb begin
    state_d = state_q; bit_cnt_d = bit_cnt_q; rx_d = rx_q; tx_d = tx_q;
    ptr_d = ptr_q; rw_d = rw_q; sda_o_d = sda_o_q;
    wr_en = 1'b0; rd_load = 1'b0; rd_addr = ptr_q;
    if (start_det) begin
      state_d = S_ADDR; bit_cnt_d = 4'd0; sda_o_d = IIC_NACK;
    end else if (stop_det) begin
      state_d = S_IDLE; bit_cnt_d = 4'd0; sda_o_d = IIC_NACK;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WR_DATA: begin
          if (scl_rise) begin
            rx_d = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_done) begin
              bit_cnt_d = 4'd0;
              if (state_q == S_ADDR) begin
                if (rx_q == DEVICE_ADDR) begin
                  state_d = S_ADDR_ACK; rw_d = sda_sync; rd_load = sda_sync;
                end else begin
                  state_d = S_WAIT_STOP;
                end
              end else if (state_q == S_PTR) begin
                ptr_d = rx_byte[PW-1:0]; state_d = S_PTR_ACK;
              end else begin
                wr_en = (ptr_q != PTR_ZERO); ptr_d = ptr_inc; state_d = S_WR_ACK;
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_o_d = IIC_ACK;
            end else begin
              bit_cnt_d = 4'd0;
              sda_o_d = IIC_NACK;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d = S_RD_DATA; sda_o_d = tx_q[7];
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WR_DATA;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == IIC_BITS) begin
              state_d = S_RD_MACK; bit_cnt_d = 4'd0; sda_o_d = IIC_NACK;
            end else begin
              sda_o_d = tx_q[3'd7 - bit_cnt_q[2:0]];
            end
          end else begin
            state_d = state_q;
          end
        end
        S_RD_MACK: begin
          if (scl_rise) begin
            if (sda_sync == IIC_ACK) begin
              ptr_d = ptr_inc; rd_load = 1'b1; rd_addr = ptr_inc; bit_cnt_d = 4'd1;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d = S_RD_DATA; bit_cnt_d = 4'd0; sda_o_d = tx_q[7];
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = state_q;
      endcase
    end
    if (rd_load) tx_d = reg_read(rd_addr);
    else tx_d = tx_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; bit_cnt_q <= 4'd0; rx_q <= 7'd0; tx_q <= 8'd0;
      ptr_q <= PTR_ZERO; rw_q <= 1'b0; sda_o_q <= 1'b1;
    end else begin
      state_q <= state_d; bit_cnt_q <= bit_cnt_d; rx_q <= rx_d; tx_q <= tx_d;
      ptr_q <= ptr_d; rw_q <= rw_d; sda_o_q <= sda_o_d;
    end
  end

  // Register 0 is never written; reads of it return DEVID_VALUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

`ifdef IIC_SLAVE_IRQ_EN
  logic irq_q, irq_d, wrote_q, wrote_d;

  // Set (on STOP after a committed write) takes priority over clear
  always_comb begin
    irq_d = irq_q; wrote_d = wrote_q;
    if (rd_load && (8'(rd_addr) == IRQ_CLR_REG)) irq_d = 1'b0;
    else irq_d = irq_q;
    if (wr_en) wrote_d = 1'b1;
    else wrote_d = wrote_q;
    if (stop_det) begin
      wrote_d = 1'b0;
      if (wrote_q) irq_d = 1'b1;
      else irq_d = irq_d;
    end else begin
      wrote_d = wrote_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0; wrote_q <= 1'b0;
    end else begin
      irq_q <= irq_d; wrote_q <= wrote_d;
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  assign IIC_SCL_O = 1'b1;
  assign IIC_SDA_O = sda_o_q;

endmodule

// File: tb/tb_iic_slave_regfile.sv
// Directed bench: bit-banged I2C master against the register-file slave.
module tb_iic_slave_regfile;

`ifdef IIC_SLAVE_IRQ_EN
  localparam logic EXP_IRQ = 1'b1;
`else
  localparam logic EXP_IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic scl_o, sda_o, irq, sda_bus;
  int n_cmp = 0;
  int n_fail = 0;
  int low_cnt = 0;

  assign sda_bus = sda_m & sda_o;

  iic_slave_regfile dut (
    .clk(clk), .reset(reset), .IIC_SCL_I(scl_m), .IIC_SDA_I(sda_bus),
    .IIC_SCL_O(scl_o), .IIC_SDA_O(sda_o), .IRQ(irq)
  );

  always #5 clk = ~clk;

  // Counts every sampled cycle in which the slave pulls SDA low
  always @(negedge clk) if (sda_o === 1'b0) low_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; cyc(10); sda_m = 1'b0; cyc(10); scl_m = 1'b0; cyc(2);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; cyc(10); scl_m = 1'b1; cyc(10); sda_m = 1'b0; cyc(10); scl_m = 1'b0; cyc(2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; cyc(10); scl_m = 1'b1; cyc(10); sda_m = 1'b1; cyc(12);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; cyc(10); scl_m = 1'b1; cyc(12); scl_m = 1'b0; cyc(2);
    end
    sda_m = 1'b1; cyc(10); scl_m = 1'b1; cyc(6); ack = sda_bus; cyc(6); scl_m = 1'b0; cyc(2);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(10); scl_m = 1'b1; cyc(6); b = {b[6:0], sda_bus}; cyc(6); scl_m = 1'b0; cyc(2);
    end
    sda_m = nack; cyc(10); scl_m = 1'b1; cyc(12); scl_m = 1'b0; cyc(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(3);
    n_cmp++; if (sda_o !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda_o); end
    reset = 1'b0; cyc(5);
    n_cmp++; if (sda_o !== 1'b1) begin n_fail++; $display("FAIL idle_sda: got %b want 1", sda_o); end
    n_cmp++; if (scl_o !== 1'b1) begin n_fail++; $display("FAIL scl_o: got %b want 1", scl_o); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d;
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h2D, a1); wr_byte(8'h08, a2); bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (irq !== EXP_IRQ) begin n_fail++; $display("FAIL write_irq: got %b want %b", irq, EXP_IRQ); end
    bus_start(); wr_byte(8'hA6, a3); wr_byte(8'h2D, a4); bus_rstart(); wr_byte(8'hA7, a5);
    rd_byte(1'b1, d); bus_stop();
    n_cmp++; if ({a3, a4, a5} !== 3'b000) begin n_fail++; $display("FAIL readback_acks: got %b want 000", {a3, a4, a5}); end
    n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL readback_2d: got %h want 08", d); end
  endtask

  task automatic test_mismatch();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    int c;
    c = low_cnt;
    bus_start(); wr_byte(8'h3A, a0); wr_byte(8'h2D, a1); wr_byte(8'h77, a2); bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL mismatch_acks: got %b want 111", {a0, a1, a2}); end
    n_cmp++; if (low_cnt !== c) begin n_fail++; $display("FAIL mismatch_sda_low: got %0d low cycles want 0", low_cnt - c); end
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h2D, a1); bus_rstart(); wr_byte(8'hA7, a3);
    rd_byte(1'b1, d); bus_stop();
    n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL mismatch_unchanged: got %h want 08", d); end
  endtask

  task automatic test_burst_wrap();
    logic a0, a1, a2, a3, a4;
    logic [7:0] d0, d1, d2, dx;
    int c;
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h3E, a1); wr_byte(8'h11, a2); wr_byte(8'h22, a3);
    wr_byte(8'h33, a4); bus_stop();
    n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin n_fail++; $display("FAIL burst_wr_acks: got %b want 00000", {a0, a1, a2, a3, a4}); end
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h3E, a1); bus_rstart(); wr_byte(8'hA7, a2);
    rd_byte(1'b0, d0); rd_byte(1'b0, d1); rd_byte(1'b1, d2);
    n_cmp++; if (d0 !== 8'h11) begin n_fail++; $display("FAIL burst_rd0: got %h want 11", d0); end
    n_cmp++; if (d1 !== 8'h22) begin n_fail++; $display("FAIL burst_rd1: got %h want 22", d1); end
    n_cmp++; if (d2 !== 8'hE5) begin n_fail++; $display("FAIL burst_rd_wrap: got %h want e5", d2); end
    c = low_cnt;
    rd_byte(1'b1, dx);
    n_cmp++; if (dx !== 8'hFF || low_cnt !== c) begin n_fail++; $display("FAIL wait_stop_quiet: got %h/%0d want ff/0", dx, low_cnt - c); end
    bus_stop();
  endtask

  task automatic test_irq_clear();
    logic a0, a1, a2;
    logic [7:0] d;
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h10, a1); wr_byte(8'h5A, a2); bus_stop();
    n_cmp++; if (irq !== EXP_IRQ) begin n_fail++; $display("FAIL irq_set: got %b want %b", irq, EXP_IRQ); end
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h30, a1); bus_rstart(); wr_byte(8'hA7, a2);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear_on_load: got %b want 0", irq); end
    rd_byte(1'b1, d); bus_stop();
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL irq_reg_data: got %h want 00", d); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_read: got %b want 0", irq); end
  endtask

  task automatic test_reg0();
    logic a0, a1, a2;
    logic [7:0] d;
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h00, a1); wr_byte(8'h55, a2); bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL reg0_acks: got %b want 000", {a0, a1, a2}); end
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h00, a1); bus_rstart(); wr_byte(8'hA7, a2);
    rd_byte(1'b1, d); bus_stop();
    n_cmp++; if (d !== 8'hE5) begin n_fail++; $display("FAIL reg0_devid: got %h want e5", d); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1, d2;
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h05, a1); wr_byte(8'h0F, a2); bus_stop();
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h05, a1); bus_rstart(); wr_byte(8'hA7, a2);
    cyc(6);
    n_cmp++; if (sda_o !== 1'b0) begin n_fail++; $display("FAIL mid_read_drive0: got %b want 0", sda_o); end
    reset = 1'b1; #1;
    n_cmp++; if (sda_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_sda: got %b want 1", sda_o); end
    cyc(3); reset = 1'b0; cyc(3);
    bus_stop();
    n_cmp++; if (sda_o !== 1'b1 || irq !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got sda %b irq %b want 1 0", sda_o, irq); end
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h07, a1); wr_byte(8'h9C, a2); bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL post_reset_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (irq !== EXP_IRQ) begin n_fail++; $display("FAIL post_reset_irq: got %b want %b", irq, EXP_IRQ); end
    bus_start(); wr_byte(8'hA6, a0); wr_byte(8'h05, a1); bus_rstart(); wr_byte(8'hA7, a2);
    rd_byte(1'b0, d0); rd_byte(1'b0, d1); rd_byte(1'b1, d2); bus_stop();
    n_cmp++; if ({d0, d1} !== 16'h0000) begin n_fail++; $display("FAIL post_reset_cleared: got %h want 0000", {d0, d1}); end
    n_cmp++; if (d2 !== 8'h9C) begin n_fail++; $display("FAIL post_reset_data: got %h want 9c", d2); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_burst_wrap();
    test_irq_clear();
    test_reg0();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave_regfile.md
# iic_slave_regfile

Parametrised I2C slave with an addressable register file, used in testbenches as the bus-side device model behind an I2C master such as the ADXL345 controller. It detects START and STOP conditions and supports repeated START. It acknowledges its own 7-bit address, loads a register pointer, and serves write and read bursts with pointer auto-increment. Unlike the previous passive sniffer, it drives ACK and read data on SDA (open-drain emulation) and can raise an interrupt.

## Interface
- `DEVICE_ADDR`, default 7'h53: 7-bit slave address this block acknowledges.
- `REG_DEPTH`, default 64: number of 8-bit registers; power of two, 2..256.
- `DEVID_VALUE`, default 8'hE5: read-only content of register 0.
- `IRQ_CLR_REG`, default 8'h30: reading this register clears IRQ.
- `SYNC_STAGES`, default 2: synchroniser depth on SCL/SDA inputs, ≥2.
- `clk` in 1: single clock; SCL half-period ≥ 8 `clk` cycles.
- `reset` in 1: asynchronous, active-high.
- `IIC_SCL_I` in 1: bus SCL.
- `IIC_SDA_I` in 1: bus SDA.
- `IIC_SCL_O` out 1: constant 1; the block never stretches the clock.
- `IIC_SDA_O` out 1: 0 pulls SDA low, 1 releases it.
- `IRQ` out 1: sticky interrupt.

## Operation
- Inputs pass through `SYNC_STAGES` flip-flops and are then edge-detected:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Bits are sampled on the SCL rising edge. SDA_O changes only on a detected SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, WAIT_STOP.
- START from any state goes to ADDR, bit counter = 0. A repeated START keeps the pointer.
- ADDR: after 8 bits, compare bits [7:1] with `DEVICE_ADDR`.
  - Match: go to ADDR_ACK.
  - Mismatch: go to WAIT_STOP, SDA released.
- ADDR_ACK: SDA_O = 0 for the 9th clock.
  - R/W = 0: next state is PTR.
  - R/W = 1: load reg[ptr] into the output shifter; next state is RD_DATA.
- PTR: the 8-bit value is stored as ptr = value mod `REG_DEPTH`. Then PTR_ACK (ack driven), then WR_DATA.
- WR_DATA: after 8 bits, write reg[ptr] unless ptr = 0 (writes to 0 are acknowledged and discarded). Then ptr increments with wrap from `REG_DEPTH-1` to 0, and the block acks in WR_ACK.
- RD_DATA: drive MSB first.
- RD_MACK: sample SDA on the 9th rising edge.
  - Low (master ACK): ptr++, load the next byte, return to RD_DATA.
  - High (NACK): go to WAIT_STOP.
- STOP from any state: go to IDLE, SDA released, bit counter cleared.
- Register 0 always reads `DEVID_VALUE`.

## Timing
- Reset values:
  - `IIC_SDA_O` = 1, `IIC_SCL_O` = 1, `IRQ` = 0.
  - FSM in IDLE; ptr = 0; all registers = 0.
- Event detection latency: `SYNC_STAGES`+1 `clk` cycles after the pin changes.
- SDA_O is registered: it updates 1 cycle after the detected SCL fall.
- Register write commits 1 cycle after the 8th sampled data bit.
- Read data is loaded before the SCL fall that begins the byte.
- Reset asserted mid-transfer releases SDA immediately (asynchronous). After reset the block ignores the bus until the next START.
- START and STOP are mutually exclusive per cycle. An SCL edge coinciding with a START/STOP detection is ignored.

## Configuration
- `IIC_SLAVE_IRQ_EN` defined:
  - IRQ is set 1 cycle after a STOP that ends a transaction containing ≥1 committed data write.
  - IRQ is cleared when a read byte is loaded from `IRQ_CLR_REG`.
  - If set and clear occur in the same cycle, set wins.
- `IIC_SLAVE_IRQ_EN` undefined: IRQ is tied to 0 and no IRQ logic is generated.

## Structure
- Package `iic_slave_pkg`: FSM enum `iic_slave_state_t`, constant `IIC_ACK` = 1'b0, `IIC_NACK` = 1'b1, and bit-count constant 8.
- Sub-module `iic_bus_sync_detect`: SYNC_STAGES synchroniser plus outputs scl_rise, scl_fall, start_det, stop_det and sda_sync.
- Top level holds the FSM, shifters, pointer, register array and IRQ.

## Test plan
- Address match with write: START, 0xA6, ptr 0x2D, data 0x08, STOP -> ACK on all three bytes; reg[0x2D] = 0x08; IRQ = 1 (with macro).
- Address mismatch: START, 0x3A -> SDA never driven low; register file unchanged.
- Burst read with wrap: preload reg[62] = 0x11 and reg[63] = 0x22; write ptr 62; repeated START; 0xA7; read 3 bytes with ACK, ACK, NACK -> data 0x11, 0x22, 0xE5; then WAIT_STOP.
- IRQ clear: after a write, read ptr 0x30 -> IRQ falls when the byte loads. Without the macro, IRQ stays 0 throughout.
- Register 0 protection: write 0x55 to ptr 0 -> ACK is given; a later read returns 0xE5.
- Reset mid-read: assert reset while the slave drives a 0 bit -> SDA_O = 1 immediately; the next full transaction completes normally.
